// File: rtl/regfile.sv
// 32 x 32-bit integer register file with two combinational read ports, one write
// port, optional same-cycle write forwarding and a per-register pending-write scoreboard.
module regfile #(
  parameter int WRITE_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] write_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        rs1_busy,
  output logic        rs2_busy
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              byp_en;
  logic              hit1;
  logic              hit2;

  assign wr_ok = we && (rd_addr != 5'd0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[rd_addr] <= write_data;
    end
  end

  // Clear is scheduled before set so a new producer on the same index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (we) begin
        busy[rd_addr] <= 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    byp_en     = (WRITE_BYPASS != 0) && rst_n && wr_ok;
    hit1       = byp_en && (rd_addr == rs1_addr);
    hit2       = byp_en && (rd_addr == rs2_addr);
    read_data1 = '0;
    read_data2 = '0;
    if (rs1_addr != 5'd0) begin
      read_data1 = hit1 ? write_data : mem[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      read_data2 = hit2 ? write_data : mem[rs2_addr];
    end
    // A forwarded operand is already available, so it is not reported as pending.
    rs1_busy = busy[rs1_addr] && !hit1;
    rs2_busy = busy[rs2_addr] && !hit2;
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a bypassing and a non-bypassing instance share
// the same stimulus and are compared against an array-based model of the register file.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_bz1, b_bz2, n_bz1, n_bz2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  regfile #(.WRITE_BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .read_data1(b_rd1), .read_data2(b_rd2), .we(we), .rd_addr(rd_addr),
    .write_data(write_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(b_bz1), .rs2_busy(b_bz2)
  );

  regfile #(.WRITE_BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .read_data1(n_rd1), .read_data2(n_rd2), .we(we), .rd_addr(rd_addr),
    .write_data(write_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(n_bz1), .rs2_busy(n_bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (byp && we && rd_addr != 5'd0 && rd_addr == a) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (byp && we && rd_addr != 5'd0 && rd_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one rising edge, applying the architectural effect of the current inputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && rd_addr != 5'd0) m_mem[rd_addr] = write_data;
      if (we) m_busy[rd_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    issue_valid = 1'b0;
    rd_addr = 5'd0;
    issue_rd = 5'd0;
    write_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    we = 1'b1; rd_addr = 5'd5; write_data = 32'hCAFE0001;
    issue_valid = 1'b1; issue_rd = 5'd5;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    tick(); tick();
    #2;
    checks++;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
      errors++; $display("FAIL reset_bypass_read: got %h/%h expected 0/0", b_rd1, b_rd2);
    end
    checks++;
    if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin
      errors++; $display("FAIL reset_read: got %h/%h expected 0/0", n_rd1, n_rd2);
    end
    checks++;
    if ({b_bz1, b_bz2, n_bz1, n_bz2} !== 4'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0000", {b_bz1, b_bz2, n_bz1, n_bz2});
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    #2;
    checks++;
    if (b_rd1 !== 32'h0 || b_bz1 !== 1'b0) begin
      errors++; $display("FAIL reset_ignored_write: got %h busy %b expected 0 busy 0", b_rd1, b_bz1);
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; rd_addr = 5'd5; write_data = 32'hDEADBEEF;
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    tick();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    #2;
    checks++;
    if (b_rd1 !== 32'hDEADBEEF || n_rd1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_x5: got %h/%h expected deadbeef", b_rd1, n_rd1);
    end
    checks++;
    if (b_rd2 !== 32'h0 || n_rd2 !== 32'h0) begin
      errors++; $display("FAIL read_x0_port2: got %h/%h expected 0", b_rd2, n_rd2);
    end
  endtask

  task automatic test_x0();
    we = 1'b1; rd_addr = 5'd0; write_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #2;
    checks++;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
      errors++; $display("FAIL x0_no_bypass: got %h/%h expected 0", b_rd1, b_rd2);
    end
    tick();
    idle();
    #2;
    checks++;
    if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0) begin
      errors++; $display("FAIL x0_write_discard: got %h/%h expected 0", b_rd1, n_rd1);
    end
    checks++;
    if (b_bz1 !== 1'b0 || n_bz1 !== 1'b0) begin
      errors++; $display("FAIL x0_busy: got %b/%b expected 0", b_bz1, n_bz1);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; rd_addr = 5'd7; write_data = 32'hAAAA5555;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    we = 1'b1; rd_addr = 5'd7; write_data = 32'h12345678;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #2;
    checks++;
    if (b_rd1 !== 32'h12345678 || b_rd2 !== 32'h12345678) begin
      errors++; $display("FAIL bypass_data: got %h/%h expected 12345678", b_rd1, b_rd2);
    end
    checks++;
    if (b_bz1 !== 1'b0 || b_bz2 !== 1'b0) begin
      errors++; $display("FAIL bypass_busy: got %b/%b expected 0/0", b_bz1, b_bz2);
    end
    checks++;
    if (n_rd1 !== 32'hAAAA5555 || n_rd2 !== 32'hAAAA5555) begin
      errors++; $display("FAIL nobypass_old: got %h/%h expected aaaa5555", n_rd1, n_rd2);
    end
    checks++;
    if (n_bz1 !== 1'b1 || n_bz2 !== 1'b1) begin
      errors++; $display("FAIL nobypass_busy: got %b/%b expected 1/1", n_bz1, n_bz2);
    end
    tick();
    idle();
    #2;
    checks++;
    if (n_rd1 !== 32'h12345678 || n_rd2 !== 32'h12345678 || n_bz1 !== 1'b0) begin
      errors++; $display("FAIL nobypass_new: got %h/%h busy %b expected 12345678 busy 0", n_rd1, n_rd2, n_bz1);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd3;
    rs2_addr = 5'd3; rs1_addr = 5'd4;
    tick();
    idle();
    #2;
    checks++;
    if (b_bz2 !== 1'b1 || n_bz2 !== 1'b1) begin
      errors++; $display("FAIL sb_set: got %b/%b expected 1", b_bz2, n_bz2);
    end
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    #2;
    checks++;
    if (n_bz2 !== 1'b1) begin
      errors++; $display("FAIL sb_reissue: got %b expected 1", n_bz2);
    end
    we = 1'b1; rd_addr = 5'd3; write_data = 32'h00000333;
    tick();
    idle();
    #2;
    checks++;
    if (b_bz2 !== 1'b0 || n_bz2 !== 1'b0 || n_rd2 !== 32'h333) begin
      errors++; $display("FAIL sb_clear: got %b/%b data %h expected 0/0 data 333", b_bz2, n_bz2, n_rd2);
    end
    issue_valid = 1'b1; issue_rd = 5'd3;
    we = 1'b1; rd_addr = 5'd3; write_data = 32'h00000444;
    tick();
    idle();
    #2;
    checks++;
    if (b_bz2 !== 1'b1 || n_bz2 !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b/%b expected 1", b_bz2, n_bz2);
    end
    issue_valid = 1'b1; issue_rd = 5'd4;
    we = 1'b1; rd_addr = 5'd3; write_data = 32'h00000555;
    tick();
    idle();
    #2;
    checks++;
    if (n_bz2 !== 1'b0 || n_bz1 !== 1'b1) begin
      errors++; $display("FAIL sb_set_clear_diff: got x3=%b x4=%b expected x3=0 x4=1", n_bz2, n_bz1);
    end
    we = 1'b1; rd_addr = 5'd12; write_data = 32'h00000C0C;
    tick();
    idle();
    rs1_addr = 5'd12;
    #2;
    checks++;
    if (n_rd1 !== 32'hC0C || n_bz1 !== 1'b0) begin
      errors++; $display("FAIL write_nonbusy: got %h busy %b expected c0c busy 0", n_rd1, n_bz1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; rd_addr = 5'(i); write_data = 32'(i);
      tick();
    end
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    rs1_addr = 5'd9; rs2_addr = 5'd31;
    #2;
    checks++;
    if (n_rd1 !== 32'd9 || n_rd2 !== 32'd31 || n_bz1 !== 1'b1) begin
      errors++; $display("FAIL fill_before_reset: got %h/%h busy %b expected 9/1f busy 1", n_rd1, n_rd2, n_bz1);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || n_rd1 !== 32'h0 || n_rd2 !== 32'h0 ||
        b_bz1 !== 1'b0 || n_bz1 !== 1'b0) begin
      errors++; $display("FAIL async_reset_now: got %h/%h/%h/%h busy %b%b expected all 0",
                         b_rd1, b_rd2, n_rd1, n_rd2, b_bz1, n_bz1);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0 || n_bz1 !== 1'b0 || n_bz2 !== 1'b0) begin
        errors++; $display("FAIL async_reset_sweep x%0d: got %h/%h busy %b%b expected 0",
                           i, n_rd1, n_rd2, n_bz1, n_bz2);
      end
    end
    tick();
    rst_n = 1'b1;
    we = 1'b1; rd_addr = 5'd9; write_data = 32'hBEEF0009;
    tick();
    idle();
    rs1_addr = 5'd9; rs2_addr = 5'd10;
    #2;
    checks++;
    if (n_rd1 !== 32'hBEEF0009 || n_rd2 !== 32'h0 || n_bz1 !== 1'b0) begin
      errors++; $display("FAIL first_write_after_reset: got %h/%h busy %b expected beef0009/0 busy 0",
                         n_rd1, n_rd2, n_bz1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!rst_n) model_reset();
      we          = 1'($urandom_range(0, 1));
      issue_valid = 1'($urandom_range(0, 1));
      write_data  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rd_addr = 5'($urandom_range(0, 31)); issue_rd = 5'($urandom_range(0, 31));
        rs1_addr = 5'($urandom_range(0, 31)); rs2_addr = 5'($urandom_range(0, 31));
      end else begin
        rd_addr = 5'($urandom_range(0, 7)); issue_rd = 5'($urandom_range(0, 7));
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      end
      #2;
      checks++;
      if (b_rd1 !== exp_data(rs1_addr, 1'b1) || b_rd2 !== exp_data(rs2_addr, 1'b1)) begin
        errors++; $display("FAIL rand_bypass_data[%0d]: got %h/%h expected %h/%h", n, b_rd1, b_rd2,
                           exp_data(rs1_addr, 1'b1), exp_data(rs2_addr, 1'b1));
      end
      checks++;
      if (n_rd1 !== exp_data(rs1_addr, 1'b0) || n_rd2 !== exp_data(rs2_addr, 1'b0)) begin
        errors++; $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h", n, n_rd1, n_rd2,
                           exp_data(rs1_addr, 1'b0), exp_data(rs2_addr, 1'b0));
      end
      checks++;
      if ({b_bz1, b_bz2, n_bz1, n_bz2} !== {exp_busy(rs1_addr, 1'b1), exp_busy(rs2_addr, 1'b1),
                                            exp_busy(rs1_addr, 1'b0), exp_busy(rs2_addr, 1'b0)}) begin
        errors++; $display("FAIL rand_busy[%0d]: got %b%b%b%b expected %b%b%b%b", n,
                           b_bz1, b_bz2, n_bz1, n_bz2,
                           exp_busy(rs1_addr, 1'b1), exp_busy(rs2_addr, 1'b1),
                           exp_busy(rs1_addr, 1'b0), exp_busy(rs2_addr, 1'b0));
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
